// File: rtl/pavana_slave_mem_ooo.sv
// pavana_slave_mem_ooo
// Memory-backed target for one crossbar slave port. Writes complete at once.
// Reads are parked in a small pending buffer and return after an
// address-dependent latency, so read responses come back out of order and
// are tagged with the original transaction id.
module pavana_slave_mem_ooo #(
  parameter int MEM_AWIDTH = 8,
  parameter int TID_WIDTH  = 2,
  parameter int NSLOTS     = 4,
  parameter int MIN_LAT    = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 slave_req,
  input  logic [31:0]          slave_addr,
  input  logic                 slave_cmd,
  input  logic [TID_WIDTH-1:0] slave_reqtid,
  input  logic [31:0]          slave_wdata,
  output logic                 slave_ack,
  output logic [TID_WIDTH-1:0] slave_resptid,
  output logic [31:0]          slave_rdata,
  output logic                 slave_resp
);

  localparam int SW    = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam int WORDS = 2 ** MEM_AWIDTH;

  // The 4-bit latency counter holds at most MIN_LAT+6-1, and the slot
  // index encoding is sized for up to eight entries.
  if (MIN_LAT < 1 || MIN_LAT > 9) begin : g_bad_min_lat
    $error("pavana_slave_mem_ooo: MIN_LAT must be in 1..9");
  end
  if (NSLOTS < 2 || NSLOTS > 8) begin : g_bad_nslots
    $error("pavana_slave_mem_ooo: NSLOTS must be in 2..8");
  end

  typedef enum logic [1:0] {
    SLOT_FREE  = 2'd0,
    SLOT_WAIT  = 2'd1,
    SLOT_READY = 2'd2
  } slot_state_e;

  // Read latency in cycles: MIN_LAT plus two cycles per step of addr[3:2].
  function automatic logic [3:0] read_latency(input logic [1:0] addr_bits);
    return 4'(MIN_LAT) + {1'b0, addr_bits, 1'b0};
  endfunction

  slot_state_e          slot_state_r [NSLOTS];
  logic [3:0]           slot_cnt_r   [NSLOTS];
  logic [TID_WIDTH-1:0] slot_tid_r   [NSLOTS];
  logic [31:0]          slot_data_r  [NSLOTS];
  logic [31:0]          mem_r        [WORDS];

  logic [MEM_AWIDTH-1:0] word_idx_s;
  logic [3:0]            lat_s;
  logic                  any_free_s;
  logic [SW-1:0]         free_idx_s;
  logic                  any_rdy_s;
  logic [SW-1:0]         rdy_idx_s;
  logic                  accept_rd_s;
  logic                  accept_wr_s;
  logic                  unused_addr_s;

  assign word_idx_s    = slave_addr[MEM_AWIDTH+1:2];
  assign lat_s         = read_latency(slave_addr[3:2]);
  assign unused_addr_s = ^{slave_addr[31:MEM_AWIDTH+2], slave_addr[1:0]};

  // Lowest-index free slot and lowest-index ready slot, from registered state only.
  always_comb begin
    any_free_s = 1'b0;
    free_idx_s = '0;
    any_rdy_s  = 1'b0;
    rdy_idx_s  = '0;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      any_free_s = any_free_s | (slot_state_r[i] == SLOT_FREE);
      free_idx_s = (slot_state_r[i] == SLOT_FREE) ? SW'(i) : free_idx_s;
      any_rdy_s  = any_rdy_s | (slot_state_r[i] == SLOT_READY);
      rdy_idx_s  = (slot_state_r[i] == SLOT_READY) ? SW'(i) : rdy_idx_s;
    end
  end

  // Writes are always accepted; reads need a free slot. Nothing is accepted
  // while reset is asserted, so a held request is simply retried afterwards.
  assign slave_ack   = rst_i & slave_req & (slave_cmd | any_free_s);
  assign accept_rd_s = slave_ack & ~slave_cmd;
  assign accept_wr_s = slave_ack &  slave_cmd;

  // Response is driven straight from the selected slot's registers.
  assign slave_resp    = any_rdy_s;
  assign slave_resptid = any_rdy_s ? slot_tid_r[rdy_idx_s]  : {TID_WIDTH{1'b0}};
  assign slave_rdata   = any_rdy_s ? slot_data_r[rdy_idx_s] : 32'h0000_0000;

  // Backing store: written on accepted writes, never reset.
  always_ff @(posedge clk_i) begin
    if (accept_wr_s) begin
      mem_r[word_idx_s] <= slave_wdata;
    end
  end

  // Per-slot FREE -> WAIT -> READY -> FREE sequencing with latency countdown.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NSLOTS; i++) begin
        slot_state_r[i] <= SLOT_FREE;
        slot_cnt_r[i]   <= 4'd0;
        slot_tid_r[i]   <= {TID_WIDTH{1'b0}};
        slot_data_r[i]  <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < NSLOTS; i++) begin
        case (slot_state_r[i])
          SLOT_FREE: begin
            if (accept_rd_s && (free_idx_s == SW'(i))) begin
              // Data is captured now, so later writes cannot alter this read.
              slot_state_r[i] <= (lat_s == 4'd1) ? SLOT_READY : SLOT_WAIT;
              slot_cnt_r[i]   <= lat_s - 4'd1;
              slot_tid_r[i]   <= slave_reqtid;
              slot_data_r[i]  <= mem_r[word_idx_s];
            end
          end
          SLOT_WAIT: begin
            slot_cnt_r[i] <= slot_cnt_r[i] - 4'd1;
            if (slot_cnt_r[i] == 4'd1) begin
              slot_state_r[i] <= SLOT_READY;
            end
          end
          SLOT_READY: begin
            if (any_rdy_s && (rdy_idx_s == SW'(i))) begin
              slot_state_r[i] <= SLOT_FREE;
            end
          end
          default: begin
            slot_state_r[i] <= SLOT_FREE;
            slot_cnt_r[i]   <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pavana_slave_mem_ooo.sv
// Testbench for pavana_slave_mem_ooo: directed scenarios plus randomized
// traffic, all checked against a slot/due-cycle reference model.
module tb_pavana_slave_mem_ooo;

  localparam int AW = 8;
  localparam int TW = 2;
  localparam int NS = 4;
  localparam int ML = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          slave_req;
  logic [31:0]   slave_addr;
  logic          slave_cmd;
  logic [TW-1:0] slave_reqtid;
  logic [31:0]   slave_wdata;
  logic          slave_ack;
  logic [TW-1:0] slave_resptid;
  logic [31:0]   slave_rdata;
  logic          slave_resp;

  always #5 clk_i = ~clk_i;

  pavana_slave_mem_ooo #(
    .MEM_AWIDTH(AW), .TID_WIDTH(TW), .NSLOTS(NS), .MIN_LAT(ML)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .slave_req(slave_req), .slave_addr(slave_addr), .slave_cmd(slave_cmd),
    .slave_reqtid(slave_reqtid), .slave_wdata(slave_wdata),
    .slave_ack(slave_ack), .slave_resptid(slave_resptid),
    .slave_rdata(slave_rdata), .slave_resp(slave_resp)
  );

  int checks   = 0;
  int failures = 0;
  int now      = 0;

  // Reference model: pending reads with absolute due cycle, plus memory image.
  bit            m_valid [NS];
  int            m_due   [NS];
  logic [TW-1:0] m_tid   [NS];
  logic [31:0]   m_data  [NS];
  logic [31:0]   mem_m   [2**AW];

  // Last sampled DUT outputs.
  logic          o_ack;
  logic          o_resp;
  logic [TW-1:0] o_tid;
  logic [31:0]   o_data;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, now);
    end
  endtask

  task automatic drive(input bit req, input bit cmd, input logic [31:0] addr,
                       input int tid, input logic [31:0] wdata);
    slave_req    = req;
    slave_cmd    = cmd;
    slave_addr   = addr;
    slave_reqtid = TW'(tid);
    slave_wdata  = wdata;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 0, 32'h0);
  endtask

  // One clock cycle: compare outputs with the model, then advance the model.
  task automatic step();
    bit   ffound, rfound, e_ack;
    int   f, r;
    int   widx;
    @(negedge clk_i);
    ffound = 1'b0; f = 0; rfound = 1'b0; r = 0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (!m_valid[i]) begin ffound = 1'b1; f = i; end
      if (m_valid[i] && m_due[i] <= now) begin rfound = 1'b1; r = i; end
    end
    e_ack = rst_i && slave_req && (slave_cmd || ffound);
    o_ack = slave_ack; o_resp = slave_resp; o_tid = slave_resptid; o_data = slave_rdata;
    check_val("ack", 32'(o_ack), 32'(e_ack));
    check_val("resp", 32'(o_resp), 32'(rfound));
    if (rfound) begin
      check_val("resptid", 32'(o_tid), 32'(m_tid[r]));
      check_val("rdata", o_data, m_data[r]);
    end
    widx = int'(slave_addr[AW+1:2]);
    if (!rst_i) begin
      for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
    end else begin
      if (rfound) m_valid[r] = 1'b0;
      if (e_ack && !slave_cmd) begin
        m_valid[f] = 1'b1;
        m_due[f]   = now + ML + 2 * int'(slave_addr[3:2]);
        m_tid[f]   = slave_reqtid;
        m_data[f]  = mem_m[widx];
      end
      if (e_ack && slave_cmd) mem_m[widx] = slave_wdata;
    end
    @(posedge clk_i);
    #1;
    now++;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 12; i++) step();
  endtask

  initial begin
    bit held;
    int idx;
    logic [31:0] a;

    for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
    rst_i = 1'b0;
    idle();
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    // Reset state.
    step();
    check_val("rst_ack", 32'(o_ack), 32'd0);
    check_val("rst_resp", 32'(o_resp), 32'd0);
    check_val("rst_tid", 32'(o_tid), 32'd0);
    check_val("rst_rdata", o_data, 32'd0);

    // Initialise the words used by later reads.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 32'(i * 4), 0, $urandom());
      step();
    end
    idle();
    step();

    // 1: write then read.
    drive(1'b1, 1'b1, 32'h10, 0, 32'hDEAD_BEEF); step();
    check_val("s1_wr_ack", 32'(o_ack), 32'd1);
    check_val("s1_wr_noresp", 32'(o_resp), 32'd0);
    drive(1'b1, 1'b0, 32'h10, 1, 32'h0); step();
    idle(); step();
    check_val("s1_early", 32'(o_resp), 32'd0);
    step();
    check_val("s1_resp", 32'(o_resp), 32'd1);
    check_val("s1_tid", 32'(o_tid), 32'd1);
    check_val("s1_data", o_data, 32'hDEAD_BEEF);
    drain();

    // 2: out-of-order return.
    drive(1'b1, 1'b0, 32'h0C, 0, 32'h0); step();
    drive(1'b1, 1'b0, 32'h00, 1, 32'h0); step();
    idle(); step();
    step();
    check_val("s2_first_tid", 32'(o_tid), 32'd1);
    check_val("s2_first_resp", 32'(o_resp), 32'd1);
    for (int i = 0; i < 4; i++) step();
    step();
    check_val("s2_second_resp", 32'(o_resp), 32'd1);
    check_val("s2_second_tid", 32'(o_tid), 32'd0);
    drain();

    // 3: full buffer, write still accepted, held read retried.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0C, i, 32'h0); step();
      check_val("s3_fill_ack", 32'(o_ack), 32'd1);
    end
    drive(1'b1, 1'b1, 32'h40, 0, 32'h1234_5678); step();
    check_val("s3_full_wr_ack", 32'(o_ack), 32'd1);
    drive(1'b1, 1'b0, 32'h08, 2, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("s3_full_rd_ack", 32'(o_ack), 32'd0);
    end
    step();
    check_val("s3_free_edge_ack", 32'(o_ack), 32'd0);
    check_val("s3_free_edge_resp", 32'(o_resp), 32'd1);
    step();
    check_val("s3_retry_ack", 32'(o_ack), 32'd1);
    drain();

    // 4: contention between two ready slots.
    drive(1'b1, 1'b0, 32'h04, 2, 32'h0); step();
    idle(); step();
    drive(1'b1, 1'b0, 32'h00, 3, 32'h0); step();
    idle(); step();
    step();
    check_val("s4_first_tid", 32'(o_tid), 32'd2);
    step();
    check_val("s4_second_resp", 32'(o_resp), 32'd1);
    check_val("s4_second_tid", 32'(o_tid), 32'd3);
    drain();

    // 5: read data captured before a following write.
    drive(1'b1, 1'b1, 32'h20, 0, 32'h1); step();
    drive(1'b1, 1'b0, 32'h20, 0, 32'h0); step();
    drive(1'b1, 1'b1, 32'h20, 0, 32'h2); step();
    idle(); step();
    check_val("s5_resp", 32'(o_resp), 32'd1);
    check_val("s5_data", o_data, 32'h1);
    drain();

    // 6: reset discards a pending read; new read after reset works.
    drive(1'b1, 1'b0, 32'h0C, 0, 32'h0); step();
    idle(); step(); step();
    rst_i = 1'b0; step();
    rst_i = 1'b1; step();
    drive(1'b1, 1'b0, 32'h00, 1, 32'h0); step();
    idle(); step();
    step();
    check_val("s6_new_resp", 32'(o_resp), 32'd1);
    check_val("s6_new_tid", 32'(o_tid), 32'd1);
    for (int i = 0; i < 14; i++) begin
      step();
      check_val("s6_no_stale_resp", 32'(o_resp), 32'd0);
    end

    // Randomized traffic; a refused request is held until accepted.
    held = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!held) begin
        idx = $urandom_range(15, 0);
        a = $urandom();
        a[AW+1:2] = AW'(idx);
        drive($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 3, a,
              $urandom_range(3, 0), $urandom());
      end
      rst_i = ($urandom_range(199, 0) != 0);
      step();
      held = slave_req && !o_ack;
    end
    rst_i = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
